// File: rtl/io_pkg.sv
// io_pkg: shared definitions for IO-window bus responders (register offsets, STATUS bits, UART FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional: IO_UART_TX_PARITY_EN adds the PARITY state to the transmitter state type.
package io_pkg;

  // Base of the CPU IO window; responders sit at fixed addresses inside it.
  localparam logic [15:0] IO_BASE = 16'h1000;

  // Register offsets from a responder's base address.
  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV_LO = 2'd2;
  localparam logic [1:0] OFS_DIV_HI = 2'd3;

  // STATUS register bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_PAR_ODD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } txState_t;

endpackage

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: CPU data-memory/IO bus as seen by one register-mapped responder.
// Latency: n/a (wiring only); rdata is registered inside the responder.
// Backpressure: none; the bus has no wait states.
// Signals: addr[15:0], wdata[7:0], we, re (IO-qualified strobes), rdata[7:0] (held until next addressed read).
interface io_uart_tx_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [7:0]  rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two, >= 2), show-ahead read.
// Latency: a pushed word is visible on popData (and empty drops) one edge after the push.
// Backpressure: push while full and pop while empty are ignored; the caller watches full/empty.
// Ports: clk, rst_n (async active-low), push/pushData, pop/popData, full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit tells full (wrapped once) from empty (equal).
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty   = (wrPtr == rdPtr);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset; empty/full come from the pointers only.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter (DATA/STATUS/DIV_LO/DIV_HI at BASE_ADDR..+3), LSB first.
// Latency: a byte written to an idle, empty block puts the start bit on tx two edges after the write edge.
// Backpressure: none on the bus; a DATA write to a full FIFO is dropped and sets sticky STATUS.overflow.
// Ports: clk, rst_n (async active-low), bus (io_uart_tx_if.slave), tx (serial out, idle high),
//        irq (high while FIFO empty and shifter idle). tx, irq and bus.rdata are registered.
// Optional: define IO_UART_TX_PARITY_EN for a parity bit before stop (11-bit frame) and STATUS bit4 parity_odd.
module io_uart_tx
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h1004,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  io_uart_tx_if.slave bus,
  output logic        tx,
  output logic        irq
);

  // ---------------- Address decode ----------------
  logic [15:0] regOfs;
  logic        inMap;
  logic [1:0]  regSel;
  logic        wrData;
  logic        wrDivLo;
  logic        wrDivHi;
  logic        rdHit;
  logic        rdStatus;

  // Subtracting the base folds the range check into "upper offset bits are zero".
  assign regOfs   = bus.addr - BASE_ADDR;
  assign inMap    = (regOfs[15:2] == 14'd0);
  assign regSel   = regOfs[1:0];
  assign wrData   = bus.we && inMap && (regSel == OFS_DATA);
  assign wrDivLo  = bus.we && inMap && (regSel == OFS_DIV_LO);
  assign wrDivHi  = bus.we && inMap && (regSel == OFS_DIV_HI);
  assign rdHit    = bus.re && inMap;
  assign rdStatus = rdHit && (regSel == OFS_STATUS);

  // ---------------- Byte FIFO ----------------
  logic       fifoFull;
  logic       fifoEmpty;
  logic       fifoPop;
  logic [7:0] fifoPopData;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wrData),
    .pushData (bus.wdata),
    .pop      (fifoPop),
    .popData  (fifoPopData),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // ---------------- Registers ----------------
  txState_t    state;
  logic [15:0] divisor;
  logic        overflow;
  logic [7:0]  rdataQ;
  logic [7:0]  statusByte;
  logic [7:0]  readMux;
`ifdef IO_UART_TX_PARITY_EN
  logic        parityOdd;
  logic        dataPar;
  logic        wrStatus;

  assign wrStatus = bus.we && inMap && (regSel == OFS_STATUS);
`endif

  always_comb begin
    statusByte              = '0;
    statusByte[STAT_BUSY]   = (state != S_IDLE);
    statusByte[STAT_FULL]   = fifoFull;
    statusByte[STAT_EMPTY]  = fifoEmpty;
    statusByte[STAT_OVF]    = overflow;
`ifdef IO_UART_TX_PARITY_EN
    statusByte[STAT_PAR_ODD] = parityOdd;
`endif
  end

  always_comb begin
    readMux = '0;
    case (regSel)
      OFS_STATUS: readMux = statusByte;
      OFS_DIV_LO: readMux = divisor[7:0];
      OFS_DIV_HI: readMux = divisor[15:8];
      default:    readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor   <= DEFAULT_DIV;
      overflow  <= 1'b0;
      rdataQ    <= '0;
`ifdef IO_UART_TX_PARITY_EN
      parityOdd <= 1'b0;
`endif
    end else begin
      if (wrDivLo) divisor[7:0]  <= bus.wdata;
      if (wrDivHi) divisor[15:8] <= bus.wdata;
      // A new overflow wins over a clearing STATUS read on the same edge,
      // so the event is never lost; the read still returns the old value.
      if (wrData && fifoFull) overflow <= 1'b1;
      else if (rdStatus)      overflow <= 1'b0;
      if (rdHit) rdataQ <= readMux;
`ifdef IO_UART_TX_PARITY_EN
      if (wrStatus) parityOdd <= bus.wdata[STAT_PAR_ODD];
`endif
    end
  end

  assign bus.rdata = rdataQ;

  // ---------------- Serialiser ----------------
  logic [7:0]  shiftReg;
  logic [2:0]  bitCnt;
  logic [15:0] baudCnt;
  logic        bitDone;
  logic        lineBit;

  assign bitDone = (baudCnt == 16'd0);
  // Pop from IDLE, or straight out of a finishing stop bit so back-to-back
  // frames have no idle gap.
  assign fifoPop = !fifoEmpty && ((state == S_IDLE) || ((state == S_STOP) && bitDone));

  always_comb begin
    lineBit = 1'b1;
    case (state)
      S_START:  lineBit = 1'b0;
      S_DATA:   lineBit = shiftReg[0];
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: lineBit = dataPar ^ parityOdd;
`endif
      default:  lineBit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      baudCnt  <= '0;
      tx       <= 1'b1;
      irq      <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
      dataPar  <= 1'b0;
`endif
    end else begin
      // tx follows the state one edge later, giving the two-edge write-to-start latency.
      tx  <= lineBit;
      irq <= fifoEmpty && (state == S_IDLE);
      if (fifoPop) begin
        shiftReg <= fifoPopData;
        baudCnt  <= divisor;
        state    <= S_START;
`ifdef IO_UART_TX_PARITY_EN
        dataPar  <= ^fifoPopData;
`endif
      end else if (state != S_IDLE) begin
        if (!bitDone) begin
          baudCnt <= baudCnt - 16'd1;
        end else begin
          // Every bit start reloads the live divisor, so a mid-frame divisor
          // write applies from the next bit onward.
          baudCnt <= divisor;
          case (state)
            S_START: begin
              state  <= S_DATA;
              bitCnt <= 3'd0;
            end
            S_DATA: begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitCnt   <= bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: state <= S_STOP;
`endif
            default: state <= S_IDLE;  // stop bit done, nothing queued
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: self-checking bench for io_uart_tx (DEFAULT_DIV=3, FIFO_DEPTH=4, BASE_ADDR=16'h1004).
// tx/irq are logged every cycle; expected line waveforms are built from the frame rules (start, 8 data
// bits LSB first, optional parity, stop; each bit divisor+1 cycles) and compared against the log.
module tb_io_uart_tx;

  localparam logic [15:0] BASE = 16'h1004;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LOG_LEN = 16384;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic irq;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic txLog  [LOG_LEN];
  logic irqLog [LOG_LEN];

  // cyc = number of rising edges so far; txLog[n] holds tx as seen after edge n.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < LOG_LEN) begin
      txLog[cyc]  = tx;
      irqLog[cyc] = irq;
    end
  end

  // Line level of frame bit k for byte b.
  function automatic logic frameBit(input logic [7:0] b, input int k, input logic odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FRAME_BITS == 11 && k == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // All bus tasks start and end just after a falling edge.
  task automatic busWrite(input logic [15:0] a, input logic [7:0] d, output int edgeNo);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.we = 1'b0;
    edgeNo = cyc;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  // Builds the expected waveform for a run of frames starting at log index firstEdge
  // (plus idle-high around it), waits until the log covers it, returns the first mismatch.
  task automatic scanStream(input int firstEdge, input logic [7:0] bytes [$], input int divFirst,
                            input int divRest, input logic odd,
                            output int badIdx, output logic gotBit, output logic expBit);
    logic expQ [$];
    expQ.push_back(1'b1);
    foreach (bytes[i]) begin
      for (int k = 0; k < FRAME_BITS; k++) begin
        int dur;
        dur = (i == 0 && k == 0) ? divFirst + 1 : divRest + 1;
        for (int j = 0; j < dur; j++) expQ.push_back(frameBit(bytes[i], k, odd));
      end
    end
    expQ.push_back(1'b1);
    expQ.push_back(1'b1);
    while (cyc < firstEdge + expQ.size() + 1) @(negedge clk);
    badIdx = -1;
    gotBit = 1'b1;
    expBit = 1'b1;
    foreach (expQ[n]) begin
      if (badIdx == -1 && txLog[firstEdge - 1 + n] !== expQ[n]) begin
        badIdx = n;
        gotBit = txLog[firstEdge - 1 + n];
        expBit = expQ[n];
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", irq); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus.rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_status got %h want 04", d); end
    busRead(BASE + 16'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div_hi got %h want 00", d); end
    busRead(BASE + 16'd2, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL reset_div_lo got %h want 03", d); end
    busRead(BASE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL data_read got %h want 00", d); end
  endtask

  task automatic test_registers();
    logic [7:0] d;
    logic [7:0] r;
    int e;
    busRead(BASE + 16'd2, d);
    repeat (3) @(negedge clk);
    checks++; if (bus.rdata !== 8'h03) begin errors++; $display("FAIL rdata_hold got %h want 03", bus.rdata); end
    busRead(BASE + 16'd4, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL unmapped_hi_read got %h want 03", d); end
    busRead(BASE - 16'd1, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL unmapped_lo_read got %h want 03", d); end
    r = 8'($urandom_range(1, 255));
    busWrite(BASE + 16'd3, r, e);
    busRead(BASE + 16'd3, d);
    checks++; if (d !== r) begin errors++; $display("FAIL div_hi_rw got %h want %h", d, r); end
    busWrite(BASE + 16'd3, 8'h00, e);
    busWrite(BASE + 16'd4, 8'h55, e);
    busRead(BASE + 16'd2, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL unmapped_write_div got %h want 03", d); end
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL unmapped_write_fifo got %h want 04", d); end
`ifdef IO_UART_TX_PARITY_EN
    busWrite(BASE + 16'd1, 8'h10, e);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL parity_odd_set got %h want 14", d); end
    busWrite(BASE + 16'd1, 8'hEF, e);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL parity_odd_clr got %h want 04", d); end
`else
    busWrite(BASE + 16'd1, 8'hFF, e);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL status_write_ignored got %h want 04", d); end
`endif
  endtask

  task automatic test_single_frame();
    logic [7:0] q [$];
    int e, bad, flen;
    logic g, x;
    flen = FRAME_BITS * 4;
    q = '{8'hA5};
    busWrite(BASE, 8'hA5, e);
    scanStream(e + 2, q, 3, 3, 1'b0, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL frame_a5 idx %0d got %b want %b", bad, g, x); end
    checks++; if (irqLog[e + 1] !== 1'b0) begin errors++; $display("FAIL irq_busy got %b want 0", irqLog[e + 1]); end
    checks++; if (irqLog[e + 1 + flen] !== 1'b0) begin errors++; $display("FAIL irq_in_stop got %b want 0", irqLog[e + 1 + flen]); end
    checks++; if (irqLog[e + 2 + flen] !== 1'b1) begin errors++; $display("FAIL irq_after_stop got %b want 1", irqLog[e + 2 + flen]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] d;
    int e0, e, bad;
    logic g, x;
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    busWrite(BASE, q[0], e0);
    for (int i = 1; i < 5; i++) busWrite(BASE, q[i], e);
    busWrite(BASE, 8'($urandom), e);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h0B) begin errors++; $display("FAIL overflow_status got %h want 0b", d); end
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL overflow_cleared got %h want 03", d); end
    scanStream(e0 + 2, q, 3, 3, 1'b0, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL back_to_back idx %0d got %b want %b", bad, g, x); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_idle got %b want 1", irq); end
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL b2b_status_idle got %h want 04", d); end
  endtask

  task automatic test_div_change();
    logic [7:0] q [$];
    int e, w, bad;
    logic g, x;
    busWrite(BASE + 16'd2, 8'h00, w);
    q = '{8'hFF};
    busWrite(BASE, 8'hFF, e);
    scanStream(e + 2, q, 0, 0, 1'b0, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL div0_frame idx %0d got %b want %b", bad, g, x); end
    busWrite(BASE + 16'd2, 8'h03, w);
    q = '{8'h55};
    busWrite(BASE, 8'h55, e);
    repeat (2) @(negedge clk);
    busWrite(BASE + 16'd2, 8'h07, w);  // lands during the start bit
    scanStream(e + 2, q, 3, 7, 1'b0, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL div_midframe idx %0d got %b want %b", bad, g, x); end
    busWrite(BASE + 16'd2, 8'h03, w);
  endtask

  task automatic test_random_frames();
    logic [7:0] q [$];
    logic [7:0] d;
    int dv, n, e0, e, bad;
    logic g, x;
    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(0, 4);
      busWrite(BASE + 16'd2, 8'(dv), e);
      busRead(BASE + 16'd2, d);
      checks++; if (d !== 8'(dv)) begin errors++; $display("FAIL rand_div_rb got %h want %h", d, 8'(dv)); end
      n = $urandom_range(1, 3);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      busWrite(BASE, q[0], e0);
      for (int i = 1; i < n; i++) busWrite(BASE, q[i], e);
      scanStream(e0 + 2, q, dv, dv, 1'b0, bad, g, x);
      checks++; if (bad != -1) begin errors++; $display("FAIL rand_frames it %0d idx %0d got %b want %b", it, bad, g, x); end
    end
    busWrite(BASE + 16'd2, 8'h03, e);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int e, s;
    logic allHigh;
    busRead(BASE + 16'd2, d);
    busWrite(BASE, 8'h00, e);
    busWrite(BASE, 8'($urandom), s);
    while (cyc < e + 14) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_data_low got %b want 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_immediate got %b want 1", tx); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata_mid got %h want 00", bus.rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = cyc;
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL fifo_empty_after_reset got %h want 04", d); end
    while (cyc < s + 61) @(negedge clk);
    allHigh = 1'b1;
    for (int i = 0; i < 60; i++) if (txLog[s + i] !== 1'b1 || irqLog[s + i] !== 1'b1) allHigh = 1'b0;
    checks++; if (allHigh !== 1'b1) begin errors++; $display("FAIL no_residual_frame got %b want 1", allHigh); end
  endtask

`ifdef IO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] q [$];
    logic [7:0] d;
    int e, w, bad;
    logic g, x;
    q = '{8'h07};
    busWrite(BASE + 16'd1, 8'h00, w);
    busWrite(BASE, 8'h07, e);
    scanStream(e + 2, q, 3, 3, 1'b0, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL parity_even idx %0d got %b want %b", bad, g, x); end
    checks++; if (txLog[e + 2 + 36] !== 1'b1) begin errors++; $display("FAIL parity_bit_even got %b want 1", txLog[e + 2 + 36]); end
    busWrite(BASE + 16'd1, 8'h10, w);
    busRead(BASE + 16'd1, d);
    checks++; if (d !== 8'h14) begin errors++; $display("FAIL parity_status got %h want 14", d); end
    busWrite(BASE, 8'h07, e);
    scanStream(e + 2, q, 3, 3, 1'b1, bad, g, x);
    checks++; if (bad != -1) begin errors++; $display("FAIL parity_odd idx %0d got %b want %b", bad, g, x); end
    checks++; if (txLog[e + 2 + 36] !== 1'b0) begin errors++; $display("FAIL parity_bit_odd got %b want 0", txLog[e + 2 + 36]); end
    busWrite(BASE + 16'd1, 8'h00, w);
  endtask
`endif

  initial begin
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_registers();
    test_single_frame();
    test_back_to_back();
    test_div_change();
    test_random_frames();
    test_reset_midframe();
`ifdef IO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped UART transmitter; a responder on the CPU data-memory/IO bus in the 0x1000–0x10FF IO window.
- CPU writes bytes into a small FIFO.
- Block serialises them 8N1, LSB first, on `tx`, using a programmable baud divisor.
- Status and divisor registers are readable/writable through the same bus.
- Bus semantics match the existing port registers: the read result is registered and held until the next addressed read.

Parameters:
BASE_ADDR, 16'h1004, address of register 0; occupies BASE_ADDR..BASE_ADDR+3.
FIFO_DEPTH, 4, byte entries; power of two, ≥2.
DEFAULT_DIV, 16'd433, divisor value at reset; bit period = divisor+1 clk cycles.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  16  bus address (CPU dMemIOAddress)
wdata  in  8  bus write data
we  in  1  bus write enable (IO-qualified)
re  in  1  bus read enable (IO-qualified)
rdata  out  8  registered read data
tx  out  1  serial output, idle high
irq  out  1  high while FIFO empty and shifter idle

Behaviour:
Reset (`rst_n`=0, asynchronous):
- tx=1, rdata=0, irq=1.
- FIFO empty, state IDLE, divisor=DEFAULT_DIV, overflow=0.
- Reset mid-frame aborts the frame; tx goes high immediately.

Register map, by offset from BASE_ADDR (addresses outside the map are ignored):
- +0 DATA. Write pushes wdata if the FIFO is not full. Read returns 0.
- +1 STATUS (read-only).
  - bit0 busy (state≠IDLE)
  - bit1 fifo_full
  - bit2 fifo_empty
  - bit3 overflow (sticky)
  - bits7:4 = 0
  - A read clears overflow on the same edge; the returned value shows the pre-clear value.
- +2 DIV_LO, +3 DIV_HI. R/W divisor bytes.

Read timing:
- rdata updates on the clk edge where re=1 and addr is in the map.
- Otherwise rdata holds its value.

Write while full:
- The write is dropped and overflow is set.
- A push to a full FIFO is dropped even if a pop occurs on the same edge.

FSM (IDLE, START, DATA, STOP):
- IDLE: tx=1. If the FIFO is non-empty, pop into the shifter, load baud counter=divisor, go to START.
- START: tx=0 for one bit period.
- DATA: tx=shift[0] for each bit; shift right; 8 bits.
- STOP: tx=1 for one bit period, then IDLE. Back-to-back bytes have no extra idle cycles.

Baud counter:
- Loads the divisor at each bit start and decrements to 0; the bit ends on the cycle after it reaches 0.
- Divisor 0 gives a 1-cycle bit.
- A divisor write mid-frame takes effect at the next bit start.

Latency:
- A write accepted on edge E0 with the FIFO empty and state IDLE makes tx go low after edge E0+2.

tx and irq are registered outputs.

Optional Feature:
Macro `IO_UART_TX_PARITY_EN`.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - STATUS bit4 = parity_odd (R/W via write to +1; this write changes bit4 only); reset 0.
  - Parity bit = XOR of the data bits, XOR parity_odd.
  - Frame is 11 bits.
- Undefined: no PARITY state, STATUS bit4 reads 0, writes to +1 are ignored, frame is 10 bits.

Decomposition:
- Shared package `io_pkg`:
  - register offset constants (OFS_DATA=0, OFS_STATUS=1, OFS_DIV_LO=2, OFS_DIV_HI=3)
  - STATUS bit indices
  - FSM state encoding typedef
  - IO window base 16'h1000
- One sub-module: `sync_fifo` (parameterised width/depth, push/pop/full/empty). It is reused later by a receiver.

Test Plan:
1. Reset with DEFAULT_DIV=3 → tx=1, irq=1; read +1 → rdata=8'h04; read +2/+3 → 8'h03, 8'h00.
2. DIV=3, write 8'hA5 to +0 → tx low 2 cycles after the write edge; bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high; 40-cycle frame; irq returns to 1 after stop.
3. Write 5 bytes back-to-back with FIFO_DEPTH=4 while IDLE:
   - the first byte pops, so all 5 are accepted;
   - a 6th write while full sets overflow;
   - read +1 → bit3=1, bit1=1;
   - a second read → bit3=0.
4. Write DIV=0 then 8'hFF → 10-cycle frame, start low 1 cycle; write DIV=7 mid-frame → the next bit lasts 8 cycles.
5. Assert rst_n=0 during DATA of byte 8'h00 → tx=1 within the same cycle; after release the FIFO is empty and no residual frame appears.
6. With `IO_UART_TX_PARITY_EN`, parity_odd=0, send 8'h07 → parity bit=1, 11-bit frame; with parity_odd=1 → parity bit=0.
